// File: rtl/faceverify_pkg.sv
`default_nettype none
// ============================================================================
// Module      : faceverify_pkg
// Description : Shared types and constants for the vector loader: FSM state
//               encoding, default parameter values and fp32 bit patterns.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package faceverify_pkg;

    localparam int D_LEN_DEFAULT   = 32;
    localparam int ELE_NUM_DEFAULT = 8;
    localparam int TIMEOUT_DEFAULT = 1024;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        LOAD_V1 = 3'd0,
        LOAD_V2 = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        OUT     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vector_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_loader_if
// Description : Bundles the element stream, MAC control/data and result
//               handshake of the vector loader.
// Ports       : slave  - the loader's view (consumes stream, drives MAC/result)
//               master - the environment's view (opposite directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_loader_if
    import faceverify_pkg::*;
#(
    parameter int D_Len   = D_LEN_DEFAULT,
    parameter int Ele_Num = ELE_NUM_DEFAULT
) ();

    logic                       s_valid;
    logic                       s_ready;
    logic [D_Len-1:0]           s_data;
    logic                       hold_ref;
    logic [D_Len-1:0]           threshold;
    logic                       mac_start;
    logic [D_Len*Ele_Num-1:0]   mac_v1;
    logic [D_Len*Ele_Num-1:0]   mac_v2;
    logic [D_Len-1:0]           mac_result;
    logic                       mac_done;
    logic                       out_valid;
    logic                       out_ready;
    logic [D_Len-1:0]           out_score;
    logic                       out_match;
    logic                       out_err;

    modport slave (
        input  s_valid, s_data, hold_ref, threshold, mac_result, mac_done, out_ready,
        output s_ready, mac_start, mac_v1, mac_v2, out_valid, out_score, out_match, out_err
    );

    modport master (
        output s_valid, s_data, hold_ref, threshold, mac_result, mac_done, out_ready,
        input  s_ready, mac_start, mac_v1, mac_v2, out_valid, out_score, out_match, out_err
    );

endinterface
`default_nettype wire

// File: rtl/fp32_cmp_ge.sv
`default_nettype none
// ============================================================================
// Module      : fp32_cmp_ge
// Description : Combinational IEEE-754 single-precision a >= b.
//               NaN on either side gives 0; +0 and -0 compare equal.
// Ports       : i_a, i_b - fp32 operands
//               o_ge     - 1 when i_a >= i_b
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_cmp_ge
    import faceverify_pkg::*;
(
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic             o_ge
);

    logic w_a_nan;
    logic w_b_nan;
    logic w_both_zero;
    logic w_mag_ge;
    logic w_mag_le;

    assign w_a_nan     = (i_a[30:23] == FP32_QNAN[30:23]) && (i_a[22:0] != 23'd0);
    assign w_b_nan     = (i_b[30:23] == FP32_QNAN[30:23]) && (i_b[22:0] != 23'd0);
    assign w_both_zero = (i_a[30:0] == 31'd0) && (i_b[30:0] == 31'd0);
    // Exponent-above-mantissa layout makes magnitude order equal unsigned order.
    assign w_mag_ge    = (i_a[30:0] >= i_b[30:0]);
    assign w_mag_le    = (i_a[30:0] <= i_b[30:0]);

    always_comb begin
        o_ge = 1'b0;
        if (w_a_nan || w_b_nan) begin
            o_ge = 1'b0;
        end else if (w_both_zero) begin
            o_ge = 1'b1;
        end else begin
            case ({i_a[31], i_b[31]})
                2'b00:   o_ge = w_mag_ge;
                2'b01:   o_ge = 1'b1;
                2'b10:   o_ge = 1'b0;
                default: o_ge = w_mag_le;   // both negative: smaller magnitude wins
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_loader.sv
`default_nettype none
// ============================================================================
// Module      : vector_loader
// Description : Packs a streamed probe vector (v1) and, unless the enrolled
//               reference is reused, a reference vector (v2); launches the
//               MAC, waits for its result with a timeout and presents score,
//               threshold decision and error flag on a valid/ready output.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - vector_loader_if.slave (stream, MAC, result)
// Revision    : 1.0 - initial release
// ============================================================================
module vector_loader
    import faceverify_pkg::*;
#(
    parameter int D_Len   = D_LEN_DEFAULT,
    parameter int Ele_Num = ELE_NUM_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    vector_loader_if.slave  bus
);

    localparam int CW = (Ele_Num > 1) ? $clog2(Ele_Num) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int VW = D_Len * Ele_Num;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              hold_q, hold_d;
    logic              s_ready_q, s_ready_d;
    logic              mac_start_q, mac_start_d;
    logic [VW-1:0]     mac_v1_q, mac_v1_d;
    logic [VW-1:0]     mac_v2_q, mac_v2_d;
    logic              out_valid_q, out_valid_d;
    logic [D_Len-1:0]  out_score_q, out_score_d;
    logic              out_match_q, out_match_d;
    logic              out_err_q, out_err_d;

    logic              w_beat;
    logic              w_last;
    logic              w_hold;
    logic              w_ge;

    fp32_cmp_ge u_cmp (
        .i_a  (bus.mac_result),
        .i_b  (bus.threshold),
        .o_ge (w_ge)
    );

    assign w_beat = bus.s_valid & s_ready_q;
    assign w_last = (cnt_q == CW'(Ele_Num - 1));
    // On the first beat hold_ref is live; on later beats use the latched copy.
    assign w_hold = (cnt_q == '0) ? bus.hold_ref : hold_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_cnt_d  = wait_cnt_q;
        hold_d      = hold_q;
        mac_v1_d    = mac_v1_q;
        mac_v2_d    = mac_v2_q;
        out_valid_d = out_valid_q;
        out_score_d = out_score_q;
        out_match_d = out_match_q;
        out_err_d   = out_err_q;

        case (state_q)
            LOAD_V1: begin
                if (w_beat) begin
                    mac_v1_d[int'(cnt_q)*D_Len +: D_Len] = bus.s_data;
                    if (cnt_q == '0) begin
                        hold_d = bus.hold_ref;
                    end
                    if (w_last) begin
                        cnt_d   = '0;
                        state_d = w_hold ? START : LOAD_V2;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_V2: begin
                if (w_beat) begin
                    mac_v2_d[int'(cnt_q)*D_Len +: D_Len] = bus.s_data;
                    if (w_last) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // A result in the final waiting cycle still beats the timeout.
                if (bus.mac_done) begin
                    out_score_d = bus.mac_result;
                    out_match_d = w_ge;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    out_score_d = D_Len'(FP32_ZERO);
                    out_match_d = 1'b0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = LOAD_V1;
                end
            end
            default: begin
                state_d = LOAD_V1;
            end
        endcase

        // Registered strobes follow the next state so they line up with it.
        s_ready_d   = (state_d == LOAD_V1) || (state_d == LOAD_V2);
        mac_start_d = (state_d == START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_V1;
            cnt_q       <= '0;
            wait_cnt_q  <= '0;
            hold_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            mac_start_q <= 1'b0;
            mac_v1_q    <= '0;
            mac_v2_q    <= '0;
            out_valid_q <= 1'b0;
            out_score_q <= '0;
            out_match_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            hold_q      <= hold_d;
            s_ready_q   <= s_ready_d;
            mac_start_q <= mac_start_d;
            mac_v1_q    <= mac_v1_d;
            mac_v2_q    <= mac_v2_d;
            out_valid_q <= out_valid_d;
            out_score_q <= out_score_d;
            out_match_q <= out_match_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mac_start = mac_start_q;
    assign bus.mac_v1    = mac_v1_q;
    assign bus.mac_v2    = mac_v2_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_score = out_score_q;
    assign bus.out_match = out_match_q;
    assign bus.out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_loader
// Description : Self-checking bench for vector_loader. A driver issues frames
//               and pushes expected MAC vectors and results into queues; a
//               monitor pops and compares whenever the DUT presents them.
// Ports       : none (top-level bench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_loader;

    localparam int DL = 32;
    localparam int EN = 8;
    localparam int TO = 24;
    localparam int VW = DL * EN;

    typedef struct {
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
        int            nbeats;
    } exp_mac_t;

    typedef struct {
        logic [31:0] score;
        bit          match;
        bit          err;
        int          lat;
    } exp_out_t;

    logic clk;
    logic rst_n;

    vector_loader_if #(.D_Len(DL), .Ele_Num(EN)) bus ();

    vector_loader #(.D_Len(DL), .Ele_Num(EN), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    exp_mac_t    exp_mac[$];
    exp_out_t    exp_out[$];

    logic [31:0] f_v1 [EN];
    logic [31:0] f_v2 [EN];
    logic [31:0] ref_v2 [EN];
    bit          ref_v2_valid = 1'b0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // ---------------- reference model (plain real arithmetic) ---------------
    function automatic bit m_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic real m_val(input logic [31:0] x);
        real mag;
        int  e;
        e = int'(x[30:23]);
        if (e == 255)    mag = 1.0e300;
        else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149.0));
        else             mag = (real'(x[22:0]) + 8388608.0) * (2.0 ** (real'(e) - 150.0));
        return x[31] ? -mag : mag;
    endfunction

    function automatic bit m_ge(input logic [31:0] a, input logic [31:0] b);
        if (m_nan(a) || m_nan(b)) return 1'b0;
        return m_val(a) >= m_val(b);
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = 32'h0000_0000;
            1: r = 32'h8000_0000;
            2: r = {r[31], 8'hFF, (r[22:0] | 23'd1)};
            3: r = {r[31], 8'hFF, 23'd0};
            4: r = {r[31], 8'h00, r[22:0]};
            default: r = {r[31], 8'(100 + $urandom_range(0, 60)), r[22:0]};
        endcase
        return r;
    endfunction

    // ---------------- driver helpers ----------------------------------------
    task automatic do_reset(input int n);
        rst_n         = 1'b0;
        bus.s_valid   = 1'b0;
        bus.mac_done  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
        ref_v2_valid = 1'b0;
        @(negedge clk);
        chk("s_ready_before_first_clock", VW'(bus.s_ready), '0);
        @(posedge clk);
        #1;
    endtask

    // mode 0: MAC answers after dly; 1: MAC never answers; 2: reset while waiting
    task automatic run_frame(input bit hold, input int mode, input logic [31:0] res,
                             input logic [31:0] thr, input int dly, input int rdy_dly,
                             input int rst_beat);
        exp_mac_t em;
        exp_out_t eo;
        int       nb;
        bit       ok;

        assert (!(hold && !ref_v2_valid))
            else $error("hold_ref requested without a stored reference vector");

        nb = hold ? EN : 2 * EN;
        for (int k = 0; k < EN; k++) begin
            em.v1[k*DL +: DL] = f_v1[k];
            em.v2[k*DL +: DL] = hold ? ref_v2[k] : f_v2[k];
        end
        em.nbeats = nb;
        exp_mac.push_back(em);

        for (int k = 0; k < nb; k++) begin
            if (k == rst_beat) begin
                do_reset(3);
                void'(exp_mac.pop_back());
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            bus.s_valid  = 1'b1;
            bus.s_data   = (k < EN) ? f_v1[k] : f_v2[k-EN];
            bus.hold_ref = (k == 0) ? hold : 1'($urandom);
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (bus.s_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1 bus.s_valid = 1'b0;
            if (!ok) begin
                fail_now("beat_accept_timeout");
                return;
            end
        end

        if (!hold) begin
            for (int k = 0; k < EN; k++) ref_v2[k] = f_v2[k];
            ref_v2_valid = 1'b1;
        end

        ok = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.mac_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("mac_start_missing");
            @(posedge clk);
            #1;
            return;
        end

        if (mode == 2) begin
            repeat (3) @(posedge clk);
            #1;
            do_reset(2);
            bus.mac_done   = 1'b1;
            bus.mac_result = res;
            bus.threshold  = thr;
            @(posedge clk);
            #1 bus.mac_done = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            return;
        end

        if (mode == 0) begin
            eo.score = res;
            eo.match = m_ge(res, thr);
            eo.err   = 1'b0;
            eo.lat   = dly + 2;
            exp_out.push_back(eo);
            repeat (dly + 1) @(posedge clk);
            #1;
            bus.mac_done   = 1'b1;
            bus.mac_result = res;
            bus.threshold  = thr;
            @(posedge clk);
            #1;
            bus.mac_done   = 1'b0;
            bus.mac_result = $urandom;
            bus.threshold  = $urandom;
        end else begin
            eo.score = 32'h0;
            eo.match = 1'b0;
            eo.err   = 1'b1;
            eo.lat   = TO + 1;
            exp_out.push_back(eo);
        end

        ok = 1'b0;
        for (int t = 0; t < TO + 20; t++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now("out_valid_missing");
            return;
        end
        @(posedge clk);
        #1;
        if (mode == 1) begin
            // Late MAC completion while the error result is on display.
            bus.mac_done   = 1'b1;
            bus.mac_result = res;
            bus.threshold  = 32'h0;
            @(posedge clk);
            #1 bus.mac_done = 1'b0;
        end
        repeat (rdy_dly) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    // ---------------- driver --------------------------------------------------
    initial begin : driver
        logic [31:0] ints [EN];
        logic [31:0] r;
        logic [31:0] t;
        bit          h;
        int          md;
        int          rb;

        ints = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.hold_ref   = 1'b0;
        bus.threshold  = '0;
        bus.mac_result = '0;
        bus.mac_done   = 1'b0;
        bus.out_ready  = 1'b0;
        rst_n          = 1'b1;
        #2;
        do_reset(3);

        for (int k = 0; k < EN; k++) begin
            f_v1[k] = ints[k];
            f_v2[k] = 32'h3F80_0000;
        end
        run_frame(1'b0, 0, 32'h4210_0000, 32'h41F0_0000, 2, 0, -1);
        run_frame(1'b0, 0, 32'h4210_0000, 32'h4230_0000, 1, 5, -1);
        run_frame(1'b0, 0, 32'h4210_0000, 32'h4210_0000, 0, 1, -1);
        run_frame(1'b0, 0, 32'h8000_0000, 32'h0000_0000, 3, 0, -1);
        run_frame(1'b0, 0, 32'h7FC0_0000, 32'h0000_0000, 0, 2, -1);
        for (int k = 0; k < EN; k++) f_v1[k] = $urandom;
        run_frame(1'b1, 0, 32'h4100_0000, 32'h4110_0000, 1, 0, -1);
        run_frame(1'b1, 1, 32'h4210_0000, 32'h0000_0000, 0, 2, -1);
        run_frame(1'b1, 0, 32'hC000_0000, 32'hC040_0000, TO - 1, 0, -1);
        for (int k = 0; k < EN; k++) f_v1[k] = $urandom;
        run_frame(1'b0, 0, 32'h3F80_0000, 32'h3F80_0000, 0, 0, 3);
        run_frame(1'b0, 0, 32'h3F80_0000, 32'h4000_0000, 0, 0, -1);
        run_frame(1'b1, 2, 32'h4210_0000, 32'h0000_0000, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < EN; k++) begin
                f_v1[k] = $urandom;
                f_v2[k] = $urandom;
            end
            h  = ref_v2_valid && ($urandom_range(0, 2) == 0);
            md = $urandom_range(0, 9);
            md = (md == 0) ? 1 : ((md == 1) ? 2 : 0);
            rb = ($urandom_range(0, 12) == 0) ? $urandom_range(0, h ? EN - 1 : 2 * EN - 1) : -1;
            r  = rand_fp();
            t  = ($urandom_range(0, 3) == 0) ? r : rand_fp();
            run_frame(h, md, r, t, ($urandom_range(0, 5) == 0) ? TO - 1 : $urandom_range(0, 5),
                      $urandom_range(0, 3), rb);
        end

        repeat (10) @(posedge clk);
        chk("exp_mac_drained", VW'(exp_mac.size()), '0);
        chk("exp_out_drained", VW'(exp_out.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- monitor -------------------------------------------------
    initial begin : monitor
        int            cyc       = 0;
        int            start_cyc = 0;
        int            beat_cnt  = 0;
        bit            pend_last = 1'b0;
        bit            waiting   = 1'b0;
        bit            prev_valid = 1'b0;
        bit            prev_hs    = 1'b0;
        logic [VW-1:0] snap_v1;
        logic [VW-1:0] snap_v2;
        logic [33:0]   snap_out;
        exp_mac_t      em;
        exp_out_t      eo;

        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("reset_ctrl", VW'({bus.s_ready, bus.mac_start, bus.out_valid,
                                       bus.out_match, bus.out_err}), '0);
                chk("reset_score", VW'(bus.out_score), '0);
                chk("reset_mac_v1", bus.mac_v1, '0);
                chk("reset_mac_v2", bus.mac_v2, '0);
                beat_cnt   = 0;
                pend_last  = 1'b0;
                waiting    = 1'b0;
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
            end else begin
                if (bus.mac_start || pend_last)
                    chk("mac_start_after_last_beat", VW'(bus.mac_start), VW'(pend_last));
                if (bus.mac_start) begin
                    if (exp_mac.size() == 0) begin
                        fail_now("unexpected_mac_start");
                    end else begin
                        em = exp_mac.pop_front();
                        chk("mac_v1", bus.mac_v1, em.v1);
                        chk("mac_v2", bus.mac_v2, em.v2);
                    end
                    snap_v1   = bus.mac_v1;
                    snap_v2   = bus.mac_v2;
                    waiting   = 1'b1;
                    start_cyc = cyc;
                end else if (waiting && !bus.out_valid) begin
                    chk("mac_v1_stable", bus.mac_v1, snap_v1);
                    chk("mac_v2_stable", bus.mac_v2, snap_v2);
                end

                pend_last = 1'b0;
                if (bus.s_valid && bus.s_ready && exp_mac.size() > 0) begin
                    beat_cnt++;
                    if (beat_cnt == exp_mac[0].nbeats) begin
                        pend_last = 1'b1;
                        beat_cnt  = 0;
                    end
                end

                if (bus.out_valid) begin
                    if (!prev_valid || prev_hs) begin
                        if (exp_out.size() == 0) begin
                            fail_now("unexpected_out_valid");
                        end else begin
                            eo = exp_out.pop_front();
                            chk("out_score", VW'(bus.out_score), VW'(eo.score));
                            chk("out_match", VW'(bus.out_match), VW'(eo.match));
                            chk("out_err", VW'(bus.out_err), VW'(eo.err));
                            chk("out_latency", VW'(cyc - start_cyc), VW'(eo.lat));
                        end
                        snap_out = {bus.out_score, bus.out_match, bus.out_err};
                    end else begin
                        chk("out_stable", VW'({bus.out_score, bus.out_match, bus.out_err}),
                            VW'(snap_out));
                    end
                    chk("s_ready_low_in_out", VW'(bus.s_ready), '0);
                    waiting = 1'b0;
                end
                prev_valid = bus.out_valid;
                prev_hs    = bus.out_valid && bus.out_ready;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vector_loader.md
VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 SHALL have parameter D_Len, default 32, the IEEE-754 word width.
REQ-002 SHALL have parameter Ele_Num, default 8, the elements per vector.
REQ-003 SHALL have parameter TIMEOUT, default 1024, the maximum cycles to wait for mac_done.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports s_valid in 1, s_ready out 1, s_data in D_Len: inbound element stream.
REQ-007 SHALL have port hold_ref  in  1  reuse the stored v2 (enrolled vector); sampled on the first v1 beat of a frame.
REQ-008 SHALL have port threshold  in  D_Len  fp32 decision threshold, sampled with mac_done.
REQ-009 SHALL have ports mac_start out 1, mac_v1 out D_Len*Ele_Num, mac_v2 out D_Len*Ele_Num: drive the downstream MAC.
REQ-010 SHALL have ports mac_result in D_Len, mac_done in 1: MAC completion.
REQ-011 SHALL have ports out_valid out 1, out_ready in 1, out_score out D_Len, out_match out 1, out_err out 1.

Function
REQ-012 SHALL implement states LOAD_V1, LOAD_V2, START, WAIT, OUT.
REQ-013 SHALL accept a beat only when s_valid and s_ready are both 1; s_ready SHALL be 1 only in LOAD_V1/LOAD_V2.
REQ-014 SHALL write beat k (0-based) of a vector into bits [k*D_Len +: D_Len]; an element counter SHALL wrap to 0 after Ele_Num-1.
REQ-015 SHALL leave LOAD_V1 after beat Ele_Num-1: to START if the latched hold_ref is 1, else to LOAD_V2.
REQ-016 SHALL leave LOAD_V2 after beat Ele_Num-1 to START.
REQ-017 SHALL assert mac_start for exactly one cycle in START, then go to WAIT.
REQ-018 SHALL hold mac_v1/mac_v2 stable from START until leaving WAIT.
REQ-019 SHALL, in WAIT with mac_done=1: capture mac_result into out_score, set out_match = (mac_result >= threshold, fp32 compare), set out_err=0, then go to OUT.
REQ-020 SHALL treat the fp32 compare as follows: -0 equals +0; either operand NaN gives 0; sign-magnitude ordering otherwise.
REQ-021 SHALL, in WAIT with no mac_done for TIMEOUT cycles: set out_err=1, out_match=0, out_score=0, then go to OUT.
REQ-022 SHALL ignore mac_done outside WAIT.
REQ-023 SHALL hold out_valid=1 in OUT with stable outputs until out_ready=1; on that handshake it SHALL go to LOAD_V1 the next cycle.
REQ-024 SHALL give 1-cycle latency from the last accepted beat to mac_start, and 1 cycle from mac_done to out_valid.
REQ-025 SHALL assert hold_ref=1 on a frame only after at least one full v2 load; otherwise the result is undefined (bench-checked assertion).

Reset
REQ-026 SHALL, on rst_n=0, immediately set state=LOAD_V1, counter=0, and s_ready=0 until the first clock after release.
REQ-027 SHALL reset mac_start, out_valid, out_match, out_err, out_score, mac_v1 and mac_v2 to 0.
REQ-028 SHALL, on reset mid-frame or mid-WAIT, discard the partial frame; a mac_done arriving after reset SHALL be ignored.

Structure
REQ-029 SHALL place the state enum, the FP32 constants (0x00000000, 0x7FC00000) and the default parameters in shared package faceverify_pkg.
REQ-030 SHALL use exactly one sub-module, fp32_cmp_ge: combinational a>=b with the NaN and ±0 rules of REQ-020.

Verification
REQ-031 SHALL cover: v1=1.0..8.0, v2=all 1.0, mac_result=0x42100000 (36.0), threshold=0x41F00000 (30.0) -> one mac_start pulse, out_score=0x42100000, out_match=1.
REQ-032 SHALL cover: the same frame with threshold=0x42300000 (44.0) -> out_match=0; threshold=0x42100000 -> out_match=1 (equality).
REQ-033 SHALL cover: mac_result=0x80000000 (-0) with threshold=0x00000000 -> out_match=1; mac_result=0x7FC00000 (NaN) -> out_match=0.
REQ-034 SHALL cover: frame 2 with hold_ref=1 and 8 beats only -> mac_v2 unchanged from frame 1, mac_start one cycle after beat 7.
REQ-035 SHALL cover: mac_done withheld -> out_err=1 exactly TIMEOUT cycles after entering WAIT; a late mac_done is ignored.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles -> outputs stable and s_ready=0; rst_n pulse at beat 3 -> next frame packs from bit 0.
